// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to CDB_SZ requesting FUs per cycle and broadcasts their packets; CDB_RR_EN selects rotating priority.
// Latency: grant is combinational in the request cycle; the broadcast is registered and appears on the next cycle.
// Backpressure: an ungranted FU holds its packet and request; a grant is the only acknowledge.
package cdb_pkg;
  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  completing_reg;
    logic        valid;
  } cdb_reg_packet_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int CDB_SZ = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic            [NUM_FU-1:0]      fu_req,
  input  cdb_reg_packet_t [NUM_FU-1:0]      fu_packets,
  output logic            [NUM_FU-1:0]      fu_grant,
  output cdb_reg_packet_t [CDB_SZ-1:0]      cdb_packets,
  output logic [$clog2(CDB_SZ+1)-1:0]       cdb_count
);
  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW = $clog2(CDB_SZ + 1);

  logic [PW-1:0]                scan_start;
  logic [PW-1:0]                scan_idx;
  logic [PW-1:0]                lane_sel [CDB_SZ];
  logic [CDB_SZ-1:0]            lane_vld;
  logic [CW-1:0]                n_grant;
  cdb_reg_packet_t [CDB_SZ-1:0] lane_nxt;

`ifdef CDB_RR_EN
  logic [PW-1:0] prio_ptr;
  logic [PW-1:0] last_idx;
  assign scan_start = prio_ptr;
`else
  assign scan_start = '0;
`endif

  // Circular scan from scan_start; the k-th winner in scan order owns lane k.
  always_comb begin
    fu_grant = '0;
    lane_vld = '0;
    n_grant  = '0;
    scan_idx = '0;
    for (int k = 0; k < CDB_SZ; k++) lane_sel[k] = '0;
`ifdef CDB_RR_EN
    last_idx = scan_start;
`endif
    for (int j = 0; j < NUM_FU; j++) begin
      scan_idx = PW'((int'(scan_start) + j) % NUM_FU);
      if (!reset && fu_req[scan_idx] && (n_grant < CW'(CDB_SZ))) begin
        fu_grant[scan_idx] = 1'b1;
        for (int k = 0; k < CDB_SZ; k++) begin
          if (n_grant == CW'(k)) begin
            lane_sel[k] = scan_idx;
            lane_vld[k] = 1'b1;
          end
        end
        n_grant = n_grant + 1'b1;
`ifdef CDB_RR_EN
        last_idx = scan_idx;
`endif
      end
    end
  end

  // The request is authoritative, so the broadcast valid is forced rather than copied.
  always_comb begin
    lane_nxt = '0;
    for (int k = 0; k < CDB_SZ; k++) begin
      if (lane_vld[k]) begin
        lane_nxt[k]       = fu_packets[lane_sel[k]];
        lane_nxt[k].valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_packets <= '0;
      cdb_count   <= '0;
    end else begin
      cdb_packets <= lane_nxt;
      cdb_count   <= n_grant;
    end
  end

`ifdef CDB_RR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_ptr <= '0;
    end else if (n_grant != '0) begin
      prio_ptr <= PW'((int'(last_idx) + 1) % NUM_FU);
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=4, CDB_SZ=2); expectations follow CDB_RR_EN if defined.
// Inputs change 1 time unit after posedge; grant is sampled 3 units after posedge, lanes 1 unit after.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  typedef cdb_reg_packet_t [1:0] lanes_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [3:0]            fu_req;
  cdb_reg_packet_t [3:0] fu_packets;
  logic [3:0]            fu_grant;
  lanes_t                cdb_packets;
  logic [1:0]            cdb_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_FU(4), .CDB_SZ(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_req     (fu_req),
    .fu_packets (fu_packets),
    .fu_grant   (fu_grant),
    .cdb_packets(cdb_packets),
    .cdb_count  (cdb_count)
  );

  // Input packets carry valid=0 so the forced valid on the lanes is exercised.
  function automatic cdb_reg_packet_t pk(int i, logic v);
    cdb_reg_packet_t p;
    p.result         = 32'h0000_0100 + 32'(i);
    p.completing_reg = 6'(i + 1);
    p.valid          = v;
    return p;
  endfunction

  function automatic lanes_t exp_of(int a, int b);
    lanes_t l = '0;
    if (a >= 0) l[0] = pk(a, 1'b1);
    if (b >= 0) l[1] = pk(b, 1'b1);
    return l;
  endfunction

  task automatic load_packets();
    for (int i = 0; i < 4; i++) fu_packets[i] = pk(i, 1'b0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    fu_req = '0;
    @(posedge clock); #1;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    fu_req = 4'b1111;
    load_packets();
    #2;
    checks++;
    if (fu_grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant: got %b want 0000", fu_grant);
    end
    @(posedge clock); #1;
    checks++;
    if (cdb_count !== 2'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", cdb_count);
    end
    checks++;
    if (cdb_packets !== lanes_t'('0)) begin
      errors++; $display("FAIL reset_lanes: got %h want 0", cdb_packets);
    end
    reset  = 1'b0;
    fu_req = '0;
  endtask

  task automatic test_single_and_wrap();
    lanes_t exp_l;
    do_reset();
    load_packets();
    fu_packets[2] = '{result: 32'h0000_002A, completing_reg: 6'd7, valid: 1'b0};
    fu_req = 4'b0100;
    #2;
    checks++;
    if (fu_grant !== 4'b0100) begin
      errors++; $display("FAIL single_grant: got %b want 0100", fu_grant);
    end
    @(posedge clock); #1;
    exp_l = '0;
    exp_l[0] = '{result: 32'h0000_002A, completing_reg: 6'd7, valid: 1'b1};
    checks++;
    if (cdb_packets !== exp_l) begin
      errors++; $display("FAIL single_lanes: got %h want %h", cdb_packets, exp_l);
    end
    checks++;
    if (cdb_count !== 2'd1) begin
      errors++; $display("FAIL single_count: got %0d want 1", cdb_count);
    end
    load_packets();
    // Rotating pointer now sits at 3, so FU3 leads the scan.
    fu_req = 4'b1001;
    #2;
    checks++;
    if (fu_grant !== 4'b1001) begin
      errors++; $display("FAIL wrap_grant: got %b want 1001", fu_grant);
    end
    @(posedge clock); #1;
`ifdef CDB_RR_EN
    exp_l = exp_of(3, 0);
`else
    exp_l = exp_of(0, 3);
`endif
    checks++;
    if (cdb_packets !== exp_l || cdb_count !== 2'd2) begin
      errors++; $display("FAIL wrap_lanes: got %h cnt %0d want %h cnt 2", cdb_packets, cdb_count, exp_l);
    end
    fu_req = 4'b0011;
    #2;
    checks++;
    if (fu_grant !== 4'b0011) begin
      errors++; $display("FAIL after_wrap_grant: got %b want 0011", fu_grant);
    end
    @(posedge clock); #1;
`ifdef CDB_RR_EN
    exp_l = exp_of(1, 0);
`else
    exp_l = exp_of(0, 1);
`endif
    checks++;
    if (cdb_packets !== exp_l) begin
      errors++; $display("FAIL after_wrap_lanes: got %h want %h", cdb_packets, exp_l);
    end
    fu_req = '0;
  endtask

  task automatic test_oversubscribe();
    logic [3:0] reqs  [5] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
`ifdef CDB_RR_EN
    logic [3:0] grnts [5] = '{4'b0011, 4'b1100, 4'b0011, 4'b0000, 4'b1100};
    int         la    [5] = '{0, 2, 0, -1, 2};
    int         lb    [5] = '{1, 3, 1, -1, 3};
`else
    logic [3:0] grnts [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0011};
    int         la    [5] = '{0, 0, 0, -1, 0};
    int         lb    [5] = '{1, 1, 1, -1, 1};
`endif
    lanes_t     exp_l;
    logic [1:0] exp_c;
    do_reset();
    load_packets();
    for (int c = 0; c < 5; c++) begin
      fu_req = reqs[c];
      #2;
      checks++;
      if (fu_grant !== grnts[c]) begin
        errors++; $display("FAIL oversub_grant[%0d]: got %b want %b", c, fu_grant, grnts[c]);
      end
      @(posedge clock); #1;
      exp_l = exp_of(la[c], lb[c]);
      exp_c = (la[c] >= 0 ? 2'd1 : 2'd0) + (lb[c] >= 0 ? 2'd1 : 2'd0);
      checks++;
      if (cdb_packets !== exp_l || cdb_count !== exp_c) begin
        errors++; $display("FAIL oversub_lanes[%0d]: got %h cnt %0d want %h cnt %0d",
                           c, cdb_packets, cdb_count, exp_l, exp_c);
      end
    end
    fu_req = '0;
  endtask

  task automatic test_reset_midstream();
    lanes_t exp_l;
    do_reset();
    load_packets();
    fu_req = 4'b0100;
    @(posedge clock); #1;
    reset  = 1'b1;
    fu_req = 4'b1111;
    #2;
    checks++;
    if (fu_grant !== 4'b0000) begin
      errors++; $display("FAIL midreset_grant: got %b want 0000", fu_grant);
    end
    @(posedge clock); #1;
    checks++;
    if (cdb_packets !== lanes_t'('0) || cdb_count !== 2'd0) begin
      errors++; $display("FAIL midreset_lanes: got %h cnt %0d want 0 cnt 0", cdb_packets, cdb_count);
    end
    reset  = 1'b0;
    fu_req = 4'b1001;
    @(posedge clock); #1;
    // A cleared pointer scans from FU0 in both modes.
    exp_l = exp_of(0, 3);
    checks++;
    if (cdb_packets !== exp_l) begin
      errors++; $display("FAIL midreset_ptr: got %h want %h", cdb_packets, exp_l);
    end
    fu_req = '0;
  endtask

  task automatic test_mult_backpressure();
    cdb_reg_packet_t mult_pkt = '{result: 32'hDEAD_BEEF, completing_reg: 6'd9, valid: 1'b0};
`ifdef CDB_RR_EN
    logic [3:0] grnts [5] = '{4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    int         exp_cycle = 1;
`else
    logic [3:0] grnts [5] = '{4'b0011, 4'b0011, 4'b1000, 4'b0000, 4'b0000};
    int         exp_cycle = 2;
`endif
    logic mult_req = 1'b1;
    int   seen = 0;
    int   seen_cycle = -1;
    do_reset();
    load_packets();
    fu_packets[3] = mult_pkt;
    for (int c = 0; c < 5; c++) begin
      fu_req = {mult_req, 1'b0, (c < 2), (c < 2)};
      #2;
      checks++;
      if (fu_grant !== grnts[c]) begin
        errors++; $display("FAIL mult_grant[%0d]: got %b want %b", c, fu_grant, grnts[c]);
      end
      if (fu_grant[3]) mult_req = 1'b0;
      @(posedge clock); #1;
      for (int k = 0; k < 2; k++) begin
        if (cdb_packets[k].valid && cdb_packets[k].result == 32'hDEAD_BEEF &&
            cdb_packets[k].completing_reg == 6'd9) begin
          seen++;
          seen_cycle = c;
        end
      end
    end
    checks++;
    if (seen !== 1) begin
      errors++; $display("FAIL mult_once: got %0d broadcasts want 1", seen);
    end
    checks++;
    if (seen_cycle !== exp_cycle) begin
      errors++; $display("FAIL mult_cycle: got %0d want %0d", seen_cycle, exp_cycle);
    end
    fu_req = '0;
  endtask

  initial begin
    test_reset();
    test_single_and_wrap();
    test_oversubscribe();
    test_reset_midstream();
    test_mult_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) among the functional units that complete out of the execute stage. Each cycle it grants up to CDB_SZ of the asserted FU requests. Granted FUs see their grant (`cdb_en`) in the same cycle, and their result packets are registered and broadcast on the CDB lanes on the following cycle. Losing FUs hold their packet until granted, so backpressure is the only flow control.

## Interface
- NUM_FU, 4, number of requesting functional units (index 0..NUM_FU-1)
- CDB_SZ, 2, number of CDB broadcast lanes; 1 ≤ CDB_SZ ≤ NUM_FU
- clock  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high
- fu_req  input  NUM_FU  per-FU CDB request (the FU's `cdb_valid`)
- fu_packets  input  NUM_FU × CDB_REG_PACKET  per-FU result; fields: result[31:0], completing_reg, valid
- fu_grant  output  NUM_FU  per-FU grant; drives each FU's `cdb_en`; combinational
- cdb_packets  output  CDB_SZ × CDB_REG_PACKET  registered broadcast lanes
- cdb_count  output  $clog2(CDB_SZ+1)  number of valid lanes in cdb_packets; registered

## Operation
- Selection:
  - Scan FUs in circular order starting at `prio_ptr`.
  - The first CDB_SZ FUs with fu_req=1 are granted.
  - The k-th granted FU in scan order is assigned lane k (k = 0..CDB_SZ-1).
- Grant rules:
  - fu_grant[i]=1 only if fu_req[i]=1; never more than CDB_SZ bits set.
  - fu_grant is purely a function of fu_req, prio_ptr and reset. No input-to-output path through fu_packets.
- Capture at posedge, for each lane k:
  - Assigned lane: cdb_packets[k] ← fu_packets[i], with valid forced to 1. The request is authoritative; fu_packets[i].valid is ignored.
  - Unassigned lane: cdb_packets[k] ← all-zero packet (valid=0, result=0, completing_reg=0).
- cdb_count ← number of grants issued in that cycle.
- prio_ptr update:
  - At least one grant: prio_ptr ← (index of last granted FU + 1) mod NUM_FU.
  - No grants: prio_ptr is held.
- Lanes are always filled low-first. There is no lane k valid while lane k-1 is invalid.
- The arbiter applies no branch-mask or squash handling. FUs drop squashed packets by deasserting fu_req.

## Timing
- Grant latency: 0 cycles (same cycle as the request).
- Broadcast latency: 1 cycle after the grant cycle.
- A request that is not granted must be held by the FU. Starvation bound with CDB_RR_EN: a continuously requesting FU is granted within ceil(NUM_FU/CDB_SZ) cycles.
- Reset:
  - While reset=1, fu_grant=0.
  - Next edge: all cdb_packets are zero packets, cdb_count=0, prio_ptr=0.
  - Reset asserted mid-stream discards the grants of that cycle. No packet from that cycle is broadcast.
- Pointer wrap: prio_ptr=NUM_FU-1 wraps to scan order NUM_FU-1, 0, 1, …
- All NUM_FU requesting: exactly CDB_SZ grants.
- No requests: all lanes invalid next cycle, prio_ptr unchanged.
- CDB_SZ = NUM_FU: every request is granted each cycle; the pointer still updates.

## Configuration
- CDB_RR_EN defined: rotating priority as described above.
- CDB_RR_EN undefined:
  - Fixed priority; scan always starts at FU 0, so lower index wins.
  - prio_ptr register is not instantiated.
  - All other behaviour is identical.

## Test plan
- Reset: assert reset with fu_req=4'b1111 → fu_grant=0 during reset; next cycle cdb_count=0 and all lanes valid=0.
- Single request: fu_req=4'b0100, fu_packets[2]={result=32'h0000_002A, completing_reg=7} → fu_grant=4'b0100; next cycle lane0={2A, 7, valid=1}, lane1 invalid, cdb_count=1; prio_ptr=3.
- Oversubscription with CDB_RR_EN, all 4 FUs requesting continuously from prio_ptr=0:
  - Grants are 0011, 1100, 0011 on successive cycles.
  - Lane order is (0,1), (2,3), (0,1).
- Wrap-around: prio_ptr=3, fu_req=4'b1001 → both granted; lane0=FU3, lane1=FU0; prio_ptr becomes 1.
- Fixed priority (CDB_RR_EN undefined), fu_req=4'b1111 held 3 cycles → grant is 4'b0011 every cycle; FUs 2 and 3 are never granted.
- Mult backpressure: the mult last stage holds its result while fu_grant=0 for 2 cycles (higher-priority FUs requesting) → on the grant cycle the result appears on the CDB exactly once, one cycle later, with the correct completing_reg.
